// File: rtl/uart_mmio_pkg.sv
// Shared constants and types for the memory-mapped UART controller:
// register indices, STATUS bit positions, IEN bits and the sticky flag struct.
package uart_mmio_pkg;

  localparam logic [2:0] STATUS_IDX = 3'd0;
  localparam logic [2:0] RX_IDX     = 3'd1;
  localparam logic [2:0] TX_IDX     = 3'd2;
  localparam logic [2:0] CYCLE_IDX  = 3'd3;
  localparam logic [2:0] IEN_IDX    = 3'd4;

  localparam int ST_TX_READY = 0;
  localparam int ST_RX_VALID = 1;
  localparam int ST_TX_OVF   = 2;
  localparam int ST_RX_OVR   = 3;
  localparam int ST_RX_UDF   = 4;
  localparam int ST_RX_CNT   = 8;
  localparam int ST_TX_FREE  = 16;

  localparam int IEN_RX = 0;
  localparam int IEN_TX = 1;

  // Packed so that the struct lines up bit-for-bit with STATUS[4:2].
  typedef struct packed {
    logic rxUnderflow;
    logic rxOverrun;
    logic txOverflow;
  } flags_t;

  function automatic logic [7:0] sat8(input logic [15:0] v);
    return (v > 16'd255) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/uart_mmio_ctrl_if.sv
// CPU memory-stage bus plus byte-wide UART TX/RX handshakes for uart_mmio_ctrl.
// Handshake rule: a byte moves on a rising clk edge only when valid & ready are both
// high in that cycle; valid never depends on ready, and ready never depends on valid.
interface uart_mmio_ctrl_if #(parameter int DATA_W = 8);
  logic              stall;
  logic [4:0]        addr;
  logic              re;
  logic              we;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              irq;
  logic [DATA_W-1:0] uart_tx_data;
  logic              uart_tx_valid;
  logic              uart_tx_ready;
  logic [DATA_W-1:0] uart_rx_data;
  logic              uart_rx_valid;
  logic              uart_rx_ready;

  modport slave (
    input  stall, addr, re, we, wdata, uart_tx_ready, uart_rx_data, uart_rx_valid,
    output rdata, irq, uart_tx_data, uart_tx_valid, uart_rx_ready
  );

  modport master (
    output stall, addr, re, we, wdata, uart_tx_ready, uart_rx_data, uart_rx_valid,
    input  rdata, irq, uart_tx_data, uart_tx_valid, uart_rx_ready
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; push is ignored when full and pop when empty,
// so full/empty are the only gating a caller needs.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign dout   = mem[rdPtr];

  // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: RX/TX FIFOs, sticky error flags, free-running cycle
// counter and a maskable level interrupt. CPU-side side effects are gated by stall.
module uart_mmio_ctrl
  import uart_mmio_pkg::*;
#(
  parameter int RX_DEPTH = 8,
  parameter int TX_DEPTH = 8,
  parameter int DATA_W   = 8,
  parameter int CNT_W    = 32
) (
  input logic              clk,
  input logic              rst_n,
  uart_mmio_ctrl_if.slave  bus
);
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;
  localparam int TX_CW = $clog2(TX_DEPTH) + 1;

  logic [2:0]        idx;
  logic              rdAcc;
  logic              wrAcc;
  logic              rxPop;
  logic              txPush;
  logic              rxFull;
  logic              rxEmpty;
  logic              txFull;
  logic              txEmpty;
  logic [RX_CW-1:0]  rxCount;
  logic [TX_CW-1:0]  txCount;
  logic [DATA_W-1:0] rxDout;
  logic [DATA_W-1:0] txDout;
  flags_t            flags;
  flags_t            flagsNext;
  logic [1:0]        ien;
  logic [CNT_W-1:0]  cycleCnt;
  logic [31:0]       statusVal;
  logic [31:0]       readVal;
  logic              unusedBits;

  assign idx        = bus.addr[4:2];
  assign rdAcc      = bus.re & ~bus.stall;
  assign wrAcc      = bus.we & ~bus.stall;
  assign rxPop      = rdAcc & (idx == RX_IDX);
  assign txPush     = wrAcc & (idx == TX_IDX);
  assign unusedBits = ^{bus.addr[1:0], bus.wdata[31:DATA_W]};

  // RX push is offered every cycle; the FIFO refuses it when full, matching uart_rx_ready.
  sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(DATA_W)) rxFifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.uart_rx_valid),
    .pop   (rxPop),
    .din   (bus.uart_rx_data),
    .dout  (rxDout),
    .full  (rxFull),
    .empty (rxEmpty),
    .count (rxCount)
  );

  sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(DATA_W)) txFifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (txPush),
    .pop   (bus.uart_tx_ready),
    .din   (bus.wdata[DATA_W-1:0]),
    .dout  (txDout),
    .full  (txFull),
    .empty (txEmpty),
    .count (txCount)
  );

  assign bus.uart_rx_ready = ~rxFull;
  assign bus.uart_tx_valid = ~txEmpty;
  assign bus.uart_tx_data  = txDout;

  always_comb begin
    statusVal                    = '0;
    statusVal[ST_TX_READY]       = ~txFull;
    statusVal[ST_RX_VALID]       = ~rxEmpty;
    statusVal[ST_TX_OVF]         = flags.txOverflow;
    statusVal[ST_RX_OVR]         = flags.rxOverrun;
    statusVal[ST_RX_UDF]         = flags.rxUnderflow;
    statusVal[ST_RX_CNT +: 8]    = sat8(16'(rxCount));
    statusVal[ST_TX_FREE +: 8]   = sat8(16'(TX_DEPTH) - 16'(txCount));
  end

  always_comb begin
    readVal = '0;
    case (idx)
      STATUS_IDX: readVal = statusVal;
      RX_IDX:     readVal = rxEmpty ? 32'd0 : 32'(rxDout);
      CYCLE_IDX:  readVal = 32'(cycleCnt);
      IEN_IDX:    readVal = {30'd0, ien};
      default:    readVal = '0;
    endcase
  end

  // W1C first, then the set conditions, so a same-cycle set wins over the clear.
  always_comb begin
    flagsNext = flags;
    if (wrAcc && idx == STATUS_IDX)
      flagsNext = flags_t'(flags & ~bus.wdata[ST_RX_UDF:ST_TX_OVF]);
    if (txPush && txFull)                flagsNext.txOverflow  = 1'b1;
    if (bus.uart_rx_valid && rxFull)     flagsNext.rxOverrun   = 1'b1;
    if (rxPop && rxEmpty)                flagsNext.rxUnderflow = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rdata <= '0;
      bus.irq   <= 1'b0;
      flags     <= '0;
      ien       <= '0;
      cycleCnt  <= '0;
    end else begin
      flags   <= flagsNext;
      bus.irq <= (ien[IEN_RX] & ~rxEmpty) | (ien[IEN_TX] & txEmpty);
      if (rdAcc) bus.rdata <= readVal;
      if (wrAcc && idx == IEN_IDX) ien <= bus.wdata[1:0];
      if (wrAcc && idx == CYCLE_IDX) cycleCnt <= '0;
      else                           cycleCnt <= cycleCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Self-checking bench for uart_mmio_ctrl: register-access vector table, hand-written
// corner sequences, and a randomized phase checked against a queue-based model.
module tb_uart_mmio_ctrl;
  import uart_mmio_pkg::*;

  localparam int RXD = 8;
  localparam int TXD = 8;
  localparam int DW  = 8;
  localparam int CW  = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   nTests = 0;
  int   nFail  = 0;

  uart_mmio_ctrl_if #(.DATA_W(DW)) bus ();

  uart_mmio_ctrl #(
    .RX_DEPTH (RXD),
    .TX_DEPTH (TXD),
    .DATA_W   (DW),
    .CNT_W    (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall         = 1'b0;
    bus.addr          = '0;
    bus.re            = 1'b0;
    bus.we            = 1'b0;
    bus.wdata         = '0;
    bus.uart_tx_ready = 1'b0;
    bus.uart_rx_data  = '0;
    bus.uart_rx_valid = 1'b0;
  endtask

  task automatic doReset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic cpuWrite(input logic [2:0] i, input logic [31:0] d);
    bus.we    = 1'b1;
    bus.addr  = {i, 2'b00};
    bus.wdata = d;
    step();
    bus.we    = 1'b0;
  endtask

  task automatic cpuRead(input logic [2:0] i, output logic [31:0] d);
    bus.re   = 1'b1;
    bus.addr = {i, 2'b00};
    step();
    bus.re   = 1'b0;
    d        = bus.rdata;
  endtask

  task automatic rxPush(input logic [DW-1:0] b);
    bus.uart_rx_valid = 1'b1;
    bus.uart_rx_data  = b;
    step();
    bus.uart_rx_valid = 1'b0;
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] rxQ[$];
  logic [DW-1:0] txQ[$];
  logic          mOvf, mOvr, mUdf;

  function automatic logic [31:0] modelStatus();
    logic [31:0] s;
    s        = '0;
    s[0]     = (txQ.size() < TXD);
    s[1]     = (rxQ.size() > 0);
    s[2]     = mOvf;
    s[3]     = mOvr;
    s[4]     = mUdf;
    s[15:8]  = 8'(rxQ.size());
    s[23:16] = 8'(TXD - txQ.size());
    return s;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic        wr;
    logic [2:0]  idx;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [31:0] expRd;
    logic [2:0]  ri;
    int          op;
    logic        rdAcc, wrAcc, rxV, txRdy, irqExp, phaseA;
    logic [DW-1:0] rxD;

    idle();
    #2;
    check("reset_rdata", bus.rdata, 32'h0);
    check("reset_rx_ready", 32'(bus.uart_rx_ready), 32'h1);
    check("reset_tx_valid", 32'(bus.uart_tx_valid), 32'h0);
    check("reset_irq", 32'(bus.irq), 32'h0);
    doReset();

    vecs.push_back('{1'b0, STATUS_IDX, 32'h0,         32'h0008_0001});
    vecs.push_back('{1'b1, IEN_IDX,    32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{1'b0, IEN_IDX,    32'h0,         32'h0000_0003});
    vecs.push_back('{1'b1, IEN_IDX,    32'hFFFF_FFFE, 32'h0});
    vecs.push_back('{1'b0, IEN_IDX,    32'h0,         32'h0000_0002});
    vecs.push_back('{1'b0, 3'd5,       32'h0,         32'h0});
    vecs.push_back('{1'b1, 3'd6,       32'hDEAD_BEEF, 32'h0});
    vecs.push_back('{1'b0, 3'd6,       32'h0,         32'h0});
    vecs.push_back('{1'b1, 3'd7,       32'h0000_0001, 32'h0});
    vecs.push_back('{1'b0, 3'd7,       32'h0,         32'h0});
    vecs.push_back('{1'b0, IEN_IDX,    32'h0,         32'h0000_0002});
    vecs.push_back('{1'b0, TX_IDX,     32'h0,         32'h0});
    vecs.push_back('{1'b0, RX_IDX,     32'h0,         32'h0});
    vecs.push_back('{1'b0, STATUS_IDX, 32'h0,         32'h0008_0011});
    vecs.push_back('{1'b1, STATUS_IDX, 32'h0000_0010, 32'h0});
    vecs.push_back('{1'b0, STATUS_IDX, 32'h0,         32'h0008_0001});
    vecs.push_back('{1'b1, IEN_IDX,    32'h0,         32'h0});
    vecs.push_back('{1'b0, IEN_IDX,    32'h0,         32'h0});

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) cpuWrite(vecs[i].idx, vecs[i].wdata);
      else begin
        cpuRead(vecs[i].idx, rd);
        check($sformatf("vec%0d_reg%0d", i, vecs[i].idx), rd, vecs[i].exp);
      end
    end

    // TX ordering with the transmitter initially not ready
    doReset();
    cpuWrite(TX_IDX, 32'h0000_0141);
    cpuWrite(TX_IDX, 32'h0000_0042);
    cpuWrite(TX_IDX, 32'hFFFF_FF43);
    check("tx_valid_held", 32'(bus.uart_tx_valid), 32'h1);
    bus.uart_tx_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("tx_order%0d", k), 32'(bus.uart_tx_data), 32'(8'h41 + k));
      step();
    end
    bus.uart_tx_ready = 1'b0;
    check("tx_drained", 32'(bus.uart_tx_valid), 32'h0);
    cpuRead(STATUS_IDX, rd);
    check("tx_free_back", 32'(rd[23:16]), 32'd8);

    // TX overflow and W1C
    for (int k = 0; k < 9; k++) cpuWrite(TX_IDX, 32'(8'h60 + k));
    cpuRead(STATUS_IDX, rd);
    check("tx_ovf_status", rd, 32'h0000_0004);
    cpuWrite(STATUS_IDX, 32'h4);
    cpuRead(STATUS_IDX, rd);
    check("tx_ovf_cleared", rd, 32'h0000_0000);
    bus.uart_tx_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("tx_full_order%0d", k), 32'(bus.uart_tx_data), 32'(8'h60 + k));
      step();
    end
    bus.uart_tx_ready = 1'b0;
    check("tx_ninth_dropped", 32'(bus.uart_tx_valid), 32'h0);

    // RX fill, overrun, set-wins, full+pop+push, drain, underflow
    doReset();
    for (int k = 0; k < 8; k++) rxPush(DW'(8'h10 + k));
    check("rx_ready_full", 32'(bus.uart_rx_ready), 32'h0);
    rxPush(8'h18);
    cpuRead(STATUS_IDX, rd);
    check("rx_ovr_status", rd, 32'h0008_080B);
    bus.uart_rx_valid = 1'b1;
    bus.uart_rx_data  = 8'h99;
    cpuWrite(STATUS_IDX, 32'h8);
    bus.uart_rx_valid = 1'b0;
    cpuRead(STATUS_IDX, rd);
    check("rx_ovr_set_wins", rd, 32'h0008_080B);
    bus.uart_rx_valid = 1'b1;
    bus.uart_rx_data  = 8'h55;
    cpuRead(RX_IDX, rd);
    bus.uart_rx_valid = 1'b0;
    check("rx_pop_full_head", rd, 32'h10);
    check("rx_ready_after_pop", 32'(bus.uart_rx_ready), 32'h1);
    cpuWrite(STATUS_IDX, 32'h8);
    for (int k = 1; k < 8; k++) begin
      cpuRead(RX_IDX, rd);
      check($sformatf("rx_read%0d", k), rd, 32'(8'h10 + k));
    end
    cpuRead(RX_IDX, rd);
    check("rx_underflow_data", rd, 32'h0);
    cpuRead(STATUS_IDX, rd);
    check("rx_underflow_status", rd, 32'h0008_0011);

    // stall holds rdata and suppresses side effects
    doReset();
    rxPush(8'hA0);
    rxPush(8'hA1);
    cpuRead(STATUS_IDX, rd);
    check("stall_pre_status", rd, 32'h0008_0203);
    bus.re    = 1'b1;
    bus.addr  = {RX_IDX, 2'b00};
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("stall_hold%0d", k), bus.rdata, 32'h0008_0203);
    end
    bus.stall = 1'b0;
    step();
    bus.re = 1'b0;
    check("stall_release_pop", bus.rdata, 32'hA0);
    cpuRead(STATUS_IDX, rd);
    check("stall_one_pop", rd, 32'h0008_0103);
    bus.stall = 1'b1;
    cpuWrite(TX_IDX, 32'h77);
    bus.stall = 1'b0;
    check("stall_no_tx_push", 32'(bus.uart_tx_valid), 32'h0);
    cpuRead(CYCLE_IDX, a);
    bus.stall = 1'b1;
    cpuWrite(CYCLE_IDX, 32'h0);
    bus.stall = 1'b0;
    cpuRead(CYCLE_IDX, rd);
    check("stall_cnt_runs", rd, a + 32'd2);

    // cycle counter reset then read ten cycles later
    cpuWrite(CYCLE_IDX, 32'h1234);
    repeat (9) step();
    cpuRead(CYCLE_IDX, rd);
    check("cycle_after_write", rd, 32'd9);

    // interrupt timing
    doReset();
    cpuWrite(IEN_IDX, 32'h1);
    check("irq_idle", 32'(bus.irq), 32'h0);
    rxPush(8'h33);
    check("irq_push_plus1", 32'(bus.irq), 32'h0);
    step();
    check("irq_push_plus2", 32'(bus.irq), 32'h1);
    cpuRead(RX_IDX, rd);
    check("irq_pop_data", rd, 32'h33);
    step();
    check("irq_after_pop", 32'(bus.irq), 32'h0);
    cpuWrite(IEN_IDX, 32'h2);
    step();
    check("irq_tx_empty", 32'(bus.irq), 32'h1);
    cpuWrite(TX_IDX, 32'h99);
    step();
    check("irq_tx_nonempty", 32'(bus.irq), 32'h0);

    // asynchronous reset in the middle of traffic
    cpuWrite(IEN_IDX, 32'h3);
    rxPush(8'h44);
    cpuRead(STATUS_IDX, rd);
    step();
    bus.uart_tx_ready = 1'b1;
    bus.uart_rx_valid = 1'b1;
    bus.uart_rx_data  = 8'h66;
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_rdata", bus.rdata, 32'h0);
    check("midrst_rx_ready", 32'(bus.uart_rx_ready), 32'h1);
    check("midrst_tx_valid", 32'(bus.uart_tx_valid), 32'h0);
    check("midrst_irq", 32'(bus.irq), 32'h0);
    idle();
    step();
    rst_n = 1'b1;
    cpuRead(STATUS_IDX, rd);
    check("midrst_status", rd, 32'h0008_0001);
    cpuRead(IEN_IDX, rd);
    check("midrst_ien", rd, 32'h0);

    // randomized traffic against the queue model
    doReset();
    cpuWrite(IEN_IDX, 32'h3);
    rxQ.delete();
    txQ.delete();
    mOvf = 1'b0;
    mOvr = 1'b0;
    mUdf = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      phaseA = (cyc < 200);
      bus.stall = ($urandom_range(0, 3) == 0);
      op = $urandom_range(0, 2);
      case ($urandom_range(0, 2))
        0:       ri = STATUS_IDX;
        1:       ri = RX_IDX;
        default: ri = TX_IDX;
      endcase
      bus.re    = (op == 1);
      bus.we    = (op == 2);
      bus.addr  = {ri, 2'b00};
      bus.wdata = $urandom;
      rxV   = phaseA ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      txRdy = phaseA ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
      rxD   = DW'($urandom);
      bus.uart_rx_valid = rxV;
      bus.uart_rx_data  = rxD;
      bus.uart_tx_ready = txRdy;

      check($sformatf("rnd%0d_tx_valid", cyc), 32'(bus.uart_tx_valid), 32'(txQ.size() > 0));
      if (txQ.size() > 0)
        check($sformatf("rnd%0d_tx_data", cyc), 32'(bus.uart_tx_data), 32'(txQ[0]));
      check($sformatf("rnd%0d_rx_ready", cyc), 32'(bus.uart_rx_ready), 32'(rxQ.size() < RXD));

      rdAcc  = bus.re && !bus.stall;
      wrAcc  = bus.we && !bus.stall;
      irqExp = (rxQ.size() > 0) || (txQ.size() == 0);
      expRd  = 32'h0;
      if (ri == STATUS_IDX) expRd = modelStatus();
      else if (ri == RX_IDX && rxQ.size() > 0) expRd = 32'(rxQ[0]);

      begin
        logic rxPushOk, rxPopOk, txPushOk, txPopOk, setOvr, setUdf, setOvf;
        rxPushOk = rxV && (rxQ.size() < RXD);
        setOvr   = rxV && (rxQ.size() == RXD);
        rxPopOk  = rdAcc && (ri == RX_IDX) && (rxQ.size() > 0);
        setUdf   = rdAcc && (ri == RX_IDX) && (rxQ.size() == 0);
        txPushOk = wrAcc && (ri == TX_IDX) && (txQ.size() < TXD);
        setOvf   = wrAcc && (ri == TX_IDX) && (txQ.size() == TXD);
        txPopOk  = txRdy && (txQ.size() > 0);
        if (rxPopOk)  void'(rxQ.pop_front());
        if (rxPushOk) rxQ.push_back(rxD);
        if (txPopOk)  void'(txQ.pop_front());
        if (txPushOk) txQ.push_back(bus.wdata[DW-1:0]);
        if (wrAcc && ri == STATUS_IDX) begin
          if (bus.wdata[2]) mOvf = 1'b0;
          if (bus.wdata[3]) mOvr = 1'b0;
          if (bus.wdata[4]) mUdf = 1'b0;
        end
        if (setOvf) mOvf = 1'b1;
        if (setOvr) mOvr = 1'b1;
        if (setUdf) mUdf = 1'b1;
      end

      step();
      if (rdAcc) check($sformatf("rnd%0d_rdata_reg%0d", cyc, ri), bus.rdata, expRd);
      check($sformatf("rnd%0d_irq", cyc), 32'(bus.irq), 32'(irqExp));
    end
    idle();
    cpuRead(STATUS_IDX, rd);
    check("rnd_final_status", rd, modelStatus());

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
